// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the dmem request port.
// Optional read-lane zeroing of unmasked bytes: define DMEM_ZERO_UNMASKED_EN.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | counting down LATENCY before the commit edge
// RESP  | response presented until i_res_ready
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_req_ready,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_addr,
  input  logic [3:0]  i_req_mask,
  input  logic [31:0] i_req_wdata,
  output logic        o_res_valid,
  input  logic        i_res_ready,
  output logic [31:0] o_res_rdata,
  output logic        o_res_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx_q;
  logic [3:0]       mask_q;
  logic [31:0]      wdata_q;
  logic             ren_q, wen_q, err_q;
  logic [31:0]      rdata_q;
  logic             res_err_q;
  logic [31:0]      mem [DEPTH_WORDS];

  logic        accept, commit;
  logic [31:0] off, word_off, rd_word;
  logic        req_err;

  // Out-of-range covers subtraction wrap: addr < BASE_ADDR is checked explicitly.
  assign off      = i_req_addr - BASE_ADDR;
  assign word_off = {2'b00, off[31:2]};
  assign req_err  = (i_req_ren & i_req_wen) | (off[1:0] != 2'b00) | (i_req_mask == 4'b0000) |
                    (i_req_addr < BASE_ADDR) | (word_off >= DEPTH_WORDS);

  assign accept = (state == IDLE) && (i_req_ren || i_req_wen);
  assign commit = (state == WAIT) && (cnt == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    o_req_ready = 1'b0;
    o_res_valid = 1'b0;
    case (state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (accept) begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      RESP: begin
        o_res_valid = 1'b1;
        if (i_res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx_q   <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      idx_q   <= word_off[IDX_W-1:0];
      mask_q  <= i_req_mask;
      wdata_q <= i_req_wdata;
      ren_q   <= i_req_ren;
      wen_q   <= i_req_wen;
      err_q   <= req_err;
    end
  end

`ifdef DMEM_ZERO_UNMASKED_EN
  assign rd_word = mem[idx_q] & {{8{mask_q[3]}}, {8{mask_q[2]}}, {8{mask_q[1]}}, {8{mask_q[0]}}};
`else
  assign rd_word = mem[idx_q];
`endif

  // Response registers only change on the commit edge, so they hold after RESP.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdata_q   <= '0;
      res_err_q <= 1'b0;
    end else if (commit) begin
      rdata_q   <= (ren_q && !err_q) ? rd_word : 32'h0;
      res_err_q <= err_q;
    end
  end

  // Array is not reset; commit is low whenever reset holds the FSM in IDLE.
  always_ff @(posedge i_clk) begin
    if (commit && wen_q && !err_q) begin
      for (int b = 0; b < 4; b++) begin
        if (mask_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign o_res_rdata = rdata_q;
  assign o_res_err   = res_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one LATENCY=2 instance and one LATENCY=1 instance
// with a non-zero base, directed vector table plus randomized model-checked traffic.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [1:0]        ren, wen, res_ready;
  logic [1:0][31:0]  addr, wdata;
  logic [1:0][3:0]   mask;
  wire  [1:0]        req_ready, res_valid, res_err;
  wire  [1:0][31:0]  res_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .o_req_ready(req_ready[0]),
    .i_req_ren(ren[0]), .i_req_wen(wen[0]), .i_req_addr(addr[0]),
    .i_req_mask(mask[0]), .i_req_wdata(wdata[0]), .o_res_valid(res_valid[0]),
    .i_res_ready(res_ready[0]), .o_res_rdata(res_rdata[0]), .o_res_err(res_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1), .BASE_ADDR(32'h0000_0100)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .o_req_ready(req_ready[1]),
    .i_req_ren(ren[1]), .i_req_wen(wen[1]), .i_req_addr(addr[1]),
    .i_req_mask(mask[1]), .i_req_wdata(wdata[1]), .o_res_valid(res_valid[1]),
    .i_res_ready(res_ready[1]), .o_res_rdata(res_rdata[1]), .o_res_err(res_err[1])
  );

  function automatic int lat_of(input int s);
    return (s == 1) ? 1 : 2;
  endfunction
  function automatic longint base_of(input int s);
    return (s == 1) ? 64'h100 : 64'h0;
  endfunction
  function automatic longint depth_of(input int s);
    return (s == 1) ? 64'd16 : 64'd1024;
  endfunction

  // Reference memories, indexed by word number.
  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model(input int s, input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] m, input logic [31:0] d,
                       output logic [31:0] er, output logic ee);
    longint off;
    int     i;
    logic [31:0] word;
    off = longint'(a) - base_of(s);
    ee  = (r && w) || (a % 4 != 0) || (m == 4'b0000) || (off < 0) || ((off / 4) >= depth_of(s));
    er  = 32'h0;
    if (!ee) begin
      i    = int'(off / 4);
      word = (s == 1) ? mem1[i] : mem0[i];
      if (w) begin
        for (int b = 0; b < 4; b++) if (m[b]) word[8*b +: 8] = d[8*b +: 8];
        if (s == 1) mem1[i] = word;
        else        mem0[i] = word;
      end else begin
        er = word;
`ifdef DMEM_ZERO_UNMASKED_EN
        for (int b = 0; b < 4; b++) if (!m[b]) er[8*b +: 8] = 8'h00;
`endif
      end
    end
  endtask

  // Called #1 after a rising edge with the DUT idle.
  task automatic txn(input int s, input string name, input logic r, input logic w,
                     input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                     input int hold, input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    chk({name, " ready_before"}, 32'(req_ready[s]), 32'd1);
    ren[s] = r; wen[s] = w; addr[s] = a; mask[s] = m; wdata[s] = d;
    @(posedge clk); #1;
    ren[s] = 1'b0; wen[s] = 1'b0;
    lat = 0;
    while (!res_valid[s] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'(lat_of(s)));
    chk({name, " rdata"}, res_rdata[s], exp_rd);
    chk({name, " err"}, 32'(res_err[s]), 32'(exp_err));
    for (int k = 0; k < hold; k++) begin
      ren[s] = 1'b1; addr[s] = base_of(s) == 0 ? 32'h10 : 32'h104; mask[s] = 4'hF;
      @(posedge clk); #1;
      chk({name, " hold_valid"}, 32'(res_valid[s]), 32'd1);
      chk({name, " hold_ready"}, 32'(req_ready[s]), 32'd0);
      chk({name, " hold_rdata"}, res_rdata[s], exp_rd);
      chk({name, " hold_err"}, 32'(res_err[s]), 32'(exp_err));
    end
    ren[s] = 1'b0;
    res_ready[s] = 1'b1;
    @(posedge clk); #1;
    res_ready[s] = 1'b0;
    chk({name, " valid_after"}, 32'(res_valid[s]), 32'd0);
    chk({name, " ready_after"}, 32'(req_ready[s]), 32'd1);
    chk({name, " rdata_kept"}, res_rdata[s], exp_rd);
  endtask

  task automatic op(input int s, input string name, input logic r, input logic w,
                    input logic [31:0] a, input logic [3:0] m, input logic [31:0] d, input int hold);
    logic [31:0] er;
    logic        ee;
    model(s, r, w, a, m, d, er, ee);
    txn(s, name, r, w, a, m, d, hold, er, ee);
  endtask

  typedef struct {
    int          s;
    string       name;
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [3:0]  m;
    logic [31:0] d;
    int          hold;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  vec_t vt[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] mask_lo_rd;
    logic [31:0] er_dummy;
    logic        ee_dummy;
`ifdef DMEM_ZERO_UNMASKED_EN
    mask_lo_rd = 32'h0000_BEEF;
`else
    mask_lo_rd = 32'hDEAD_BEEF;
`endif
    vt.push_back('{0, "wr10",      0, 1, 32'h10,       4'hF,    32'hDEADBEEF, 0, 32'h0,        0});
    vt.push_back('{0, "rd10",      1, 0, 32'h10,       4'hF,    32'h0,        0, 32'hDEADBEEF, 0});
    vt.push_back('{0, "wrlane",    0, 1, 32'h10,       4'b0100, 32'h00AB0000, 0, 32'h0,        0});
    vt.push_back('{0, "rdlane",    1, 0, 32'h10,       4'hF,    32'h0,        0, 32'hDEABBEEF, 0});
    vt.push_back('{0, "rdhold",    1, 0, 32'h10,       4'hF,    32'h0,        5, 32'hDEABBEEF, 0});
    vt.push_back('{0, "errboth",   1, 1, 32'h20,       4'hF,    32'h55555555, 0, 32'h0,        1});
    vt.push_back('{0, "erralign",  1, 0, 32'h22,       4'hF,    32'h0,        0, 32'h0,        1});
    vt.push_back('{0, "errmask",   0, 1, 32'h10,       4'h0,    32'hFFFFFFFF, 0, 32'h0,        1});
    vt.push_back('{0, "errrange",  0, 1, 32'h1000,     4'hF,    32'hFFFFFFFF, 2, 32'h0,        1});
    vt.push_back('{0, "errtop",    1, 0, 32'hFFFFFFFC, 4'hF,    32'h0,        0, 32'h0,        1});
    vt.push_back('{0, "rdafter",   1, 0, 32'h10,       4'hF,    32'h0,        0, 32'hDEABBEEF, 0});
    vt.push_back('{0, "rdmasklo",  1, 0, 32'h10,       4'b0011, 32'h0,        0,
                   (mask_lo_rd == 32'hDEADBEEF) ? 32'hDEABBEEF : 32'h0000BEEF, 0});
    vt.push_back('{0, "wr40zero",  0, 1, 32'h40,       4'hF,    32'h0,        0, 32'h0,        0});
    vt.push_back('{1, "b_wr100",   0, 1, 32'h100,      4'hF,    32'hDEADBEEF, 0, 32'h0,        0});
    vt.push_back('{1, "b_rdmask",  1, 0, 32'h100,      4'b0011, 32'h0,        0, mask_lo_rd,   0});
    vt.push_back('{1, "b_rdhold",  1, 0, 32'h100,      4'hF,    32'h0,        3, 32'hDEADBEEF, 0});
    vt.push_back('{1, "b_wrlast",  0, 1, 32'h13C,      4'hF,    32'hCAFEF00D, 0, 32'h0,        0});
    vt.push_back('{1, "b_rdlast",  1, 0, 32'h13C,      4'hF,    32'h0,        0, 32'hCAFEF00D, 0});
    vt.push_back('{1, "b_errlow",  1, 0, 32'h0FC,      4'hF,    32'h0,        0, 32'h0,        1});
    vt.push_back('{1, "b_errhigh", 0, 1, 32'h140,      4'hF,    32'h11111111, 0, 32'h0,        1});
    vt.push_back('{1, "b_errwrap", 1, 0, 32'h0,        4'hF,    32'h0,        0, 32'h0,        1});
    vt.push_back('{1, "b_rd100",   1, 0, 32'h100,      4'hF,    32'h0,        0, 32'hDEADBEEF, 0});

    rst_n = 1'b0;
    ren = '0; wen = '0; res_ready = '0; addr = '0; wdata = '0; mask = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst%0d ready", s), 32'(req_ready[s]), 32'd1);
      chk($sformatf("rst%0d valid", s), 32'(res_valid[s]), 32'd0);
      chk($sformatf("rst%0d rdata", s), res_rdata[s], 32'h0);
      chk($sformatf("rst%0d err", s), 32'(res_err[s]), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vt[i]) begin
      model(vt[i].s, vt[i].r, vt[i].w, vt[i].a, vt[i].m, vt[i].d, er_dummy, ee_dummy);
      txn(vt[i].s, vt[i].name, vt[i].r, vt[i].w, vt[i].a, vt[i].m, vt[i].d,
          vt[i].hold, vt[i].er, vt[i].ee);
    end

    // Reset one cycle after accepting a write: the write must never land.
    wen[0] = 1'b1; addr[0] = 32'h40; mask[0] = 4'hF; wdata[0] = 32'h12345678;
    @(posedge clk); #1;
    wen[0] = 1'b0;
    chk("midrst accepted", 32'(req_ready[0]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst valid", 32'(res_valid[0]), 32'd0);
    chk("midrst ready", 32'(req_ready[0]), 32'd1);
    chk("midrst rdata", res_rdata[0], 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    op(0, "midrst rd40", 1, 0, 32'h40, 4'hF, 32'h0, 0);

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++)
        op(s, $sformatf("init%0d_%0d", s, i), 0, 1, 32'(base_of(s)) + 32'(4 * i), 4'hF, $urandom, 0);

    for (int n = 0; n < 80; n++) begin
      int          s, kind, rw, wi;
      logic        r, w;
      logic [31:0] a;
      logic [3:0]  m;
      s    = int'($urandom_range(1, 0));
      kind = int'($urandom_range(9, 0));
      rw   = int'($urandom_range(4, 0));
      wi   = int'($urandom_range(15, 0));
      r    = (rw <= 2);
      w    = (rw == 0) || (rw >= 3);
      a    = 32'(base_of(s)) + 32'(4 * wi);
      m    = 4'($urandom_range(15, 1));
      case (kind)
        0: a = a + 32'($urandom_range(3, 1));
        1: a = 32'(base_of(s) + 4 * depth_of(s)) + 32'(4 * wi);
        2: m = 4'h0;
        3: if (s == 1) a = 32'(4 * wi);
        default: ;
      endcase
      op(s, $sformatf("rand%0d", n), r, w, a, m, $urandom, int'($urandom_range(2, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
